// File: rtl/fetch_hazard_controller.sv
// fetch_hazard_controller
//   Fetch-stage sequencing for the 5-stage 64-bit pipeline. Each cycle it
//   decides PC advance / redirect / hold, IF/ID load / squash / hold, and
//   whether a bubble enters ID/EX. Handles taken-branch flush, load-use
//   stall, instruction-memory wait and sticky halt.
//
//   Decision priority: halt_req > br_taken > !imem_valid > load_use > normal.
//
// Parameters:
//   FLUSH_DEPTH  wrong-path slots squashed per taken branch, incl. redirect (1..7)
//   STALL_CYCLES hold cycles per load-use hazard (1..3)
//   ZERO_REG     hardwired-zero register index; never creates a hazard
//
// Ports:
//   clk, reset (sync, active-low)
//   br_taken, imem_valid, halt_req                   fetch control inputs
//   ex_mem_read, ex_rd, id_rn, id_rm, id_uses_rm     load-use detection inputs
//   pc_write_en, pc_sel_branch                       PC register control
//   ifid_write_en, ifid_flush                        IF/ID register control
//   idex_bubble                                      ID/EX NOP insert
//   fetch_state (0 RUN, 1 FLUSH, 2 STALL/WAIT, 3 HALT), halted   debug/status
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters
//   stall_cycles, flush_cycles, wait_cycles (cycles spent in STALL, FLUSH and
//   WAIT respectively; cleared by reset).
module fetch_hazard_controller #(
  parameter int FLUSH_DEPTH  = 2,
  parameter int STALL_CYCLES = 1,
  parameter int ZERO_REG     = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       br_taken,
  input  logic       imem_valid,
  input  logic       halt_req,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rm,
  output logic       pc_write_en,
  output logic       pc_sel_branch,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fetch_state,
  output logic       halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
  output logic [31:0] wait_cycles
`endif
);

  localparam int MAX_CNT = (FLUSH_DEPTH > STALL_CYCLES) ? FLUSH_DEPTH : STALL_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] STALL_RELOAD = CW'(STALL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [4:0]    ZR           = 5'(ZERO_REG);

  typedef enum logic [2:0] {
    S_RUN,
    S_FLUSH,
    S_STALL,
    S_WAIT,
    S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] fcnt, fcnt_nxt;
  logic [CW-1:0] scnt, scnt_nxt;
  logic          load_use;

  assign load_use = ex_mem_read && (ex_rd != ZR) &&
                    ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RUN;
      fcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    scnt_nxt      = scnt;
    pc_write_en   = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    halted        = 1'b0;

    if (state == S_HALT) begin
      // Sticky: only reset leaves HALT, branches are ignored.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      halted      = 1'b1;
    end else if (halt_req) begin
      ifid_flush = 1'b1;
      state_nxt  = S_HALT;
    end else if (br_taken) begin
      // Redirect is handled identically from RUN, FLUSH, STALL and WAIT;
      // any stall in progress is abandoned and the flush window restarts.
      pc_sel_branch = 1'b1;
      pc_write_en   = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      scnt_nxt      = '0;
      if (FLUSH_DEPTH > 1) begin
        fcnt_nxt  = FLUSH_RELOAD;
        state_nxt = S_FLUSH;
      end else begin
        fcnt_nxt  = '0;
        state_nxt = S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (!imem_valid) begin
            ifid_flush = 1'b1;
            state_nxt  = S_WAIT;
          end else if (load_use) begin
            idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
              scnt_nxt  = STALL_RELOAD;
              state_nxt = S_STALL;
            end
          end else begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
          end
        end
        S_FLUSH: begin
          ifid_flush = 1'b1;
          // Without a valid word the slot is not consumed: PC and fcnt hold.
          if (imem_valid) begin
            pc_write_en = 1'b1;
            if (fcnt > CNT_ONE) begin
              fcnt_nxt = fcnt - CNT_ONE;
            end else begin
              fcnt_nxt  = '0;
              state_nxt = S_RUN;
            end
          end
        end
        S_STALL: begin
          idex_bubble = 1'b1;
          if (scnt > CNT_ONE) begin
            scnt_nxt = scnt - CNT_ONE;
          end else begin
            scnt_nxt  = '0;
            state_nxt = S_RUN;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            state_nxt     = S_RUN;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (!reset) begin
      pc_write_en   = 1'b0;
      pc_sel_branch = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      halted        = 1'b0;
    end
  end

  always_comb begin
    case (state)
      S_RUN:   fetch_state = 2'd0;
      S_FLUSH: fetch_state = 2'd1;
      S_STALL: fetch_state = 2'd2;
      S_WAIT:  fetch_state = 2'd2;
      default: fetch_state = 2'd3;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
      wait_cycles  <= '0;
    end else begin
      if (state == S_STALL && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (state == S_FLUSH && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
      if (state == S_WAIT  && wait_cycles  != '1) wait_cycles  <= wait_cycles  + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Bench for fetch_hazard_controller (FLUSH_DEPTH=2, STALL_CYCLES=1, ZERO_REG=31).
// Each step drives inputs just after a rising edge and queues the expected
// output vector; the owning test task pops and compares it on the falling edge.
// Output vector: {pc_write_en, pc_sel_branch, ifid_write_en, ifid_flush,
//                 idex_bubble, halted, fetch_state[1:0]}
module tb_fetch_hazard_controller;

  logic       clk = 1'b0;
  logic       reset, br_taken, imem_valid, halt_req, ex_mem_read, id_uses_rm;
  logic [4:0] ex_rd, id_rn, id_rm;
  logic       pc_write_en, pc_sel_branch, ifid_write_en, ifid_flush, idex_bubble, halted;
  logic [1:0] fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles, wait_cycles;
`endif

  fetch_hazard_controller #(
    .FLUSH_DEPTH (2),
    .STALL_CYCLES(1),
    .ZERO_REG    (31)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .br_taken     (br_taken),
    .imem_valid   (imem_valid),
    .halt_req     (halt_req),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rm   (id_uses_rm),
    .pc_write_en  (pc_write_en),
    .pc_sel_branch(pc_sel_branch),
    .ifid_write_en(ifid_write_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fetch_state  (fetch_state),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles),
    .wait_cycles  (wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Expected output vectors, written out from the behaviour description.
  localparam logic [7:0] RST_E   = 8'b0001_1000; // reset: flush+bubble
  localparam logic [7:0] NORM    = 8'b1010_0000; // RUN normal
  localparam logic [7:0] BR_RUN  = 8'b1101_1000; // redirect from RUN
  localparam logic [7:0] BR_FL   = 8'b1101_1001; // redirect while in FLUSH
  localparam logic [7:0] BR_WT   = 8'b1101_1010; // redirect while in WAIT
  localparam logic [7:0] FLUSH_E = 8'b1001_0001; // FLUSH, valid word squashed
  localparam logic [7:0] FL_HOLD = 8'b0001_0001; // FLUSH, no valid word / halt req
  localparam logic [7:0] LU_E    = 8'b0000_1000; // load-use stall in RUN
  localparam logic [7:0] MISS    = 8'b0001_0000; // RUN, imem miss or halt req
  localparam logic [7:0] WAIT_E  = 8'b0001_0010; // WAIT, still invalid
  localparam logic [7:0] WAIT_OK = 8'b1010_0010; // WAIT, word returned
  localparam logic [7:0] HALT_E  = 8'b0001_1111; // HALT

  typedef struct packed {
    logic       rst, br, vld, hlt, mr;
    logic [4:0] rd, rn, rm;
    logic       urm;
    logic [7:0] exp, mask;
  } stim_t;

  typedef struct packed {
    logic [7:0] exp, mask;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] obs;
  int         checks = 0;
  int         errors = 0;

  assign obs = {pc_write_en, pc_sel_branch, ifid_write_en, ifid_flush,
                idex_bubble, halted, fetch_state};

  function automatic stim_t io(input logic br, input logic vld, input logic hlt,
                               input logic [7:0] exp);
    stim_t s;
    s = '{rst: 1'b1, br: br, vld: vld, hlt: hlt, mr: 1'b0, rd: 5'd0, rn: 5'd1,
          rm: 5'd2, urm: 1'b0, exp: exp, mask: 8'hFF};
    return s;
  endfunction

  function automatic stim_t ld(input logic br, input logic [4:0] rd, input logic [4:0] rn,
                               input logic [4:0] rm, input logic urm, input logic mr,
                               input logic [7:0] exp);
    stim_t s;
    s = '{rst: 1'b1, br: br, vld: 1'b1, hlt: 1'b0, mr: mr, rd: rd, rn: rn,
          rm: rm, urm: urm, exp: exp, mask: 8'hFF};
    return s;
  endfunction

  // fetch_state is not defined while reset is held, so it is masked off.
  function automatic stim_t rs();
    stim_t s;
    s = io(1'b0, 1'b1, 1'b0, RST_E);
    s.rst  = 1'b0;
    s.mask = 8'hFC;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = s.rst;
    br_taken    = s.br;
    imem_valid  = s.vld;
    halt_req    = s.hlt;
    ex_mem_read = s.mr;
    ex_rd       = s.rd;
    id_rn       = s.rn;
    id_rm       = s.rm;
    id_uses_rm  = s.urm;
    e.exp       = s.exp;
    e.mask      = s.mask;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    stim_t t [$];
    exp_t  e;
    t.push_back(rs());
    t.push_back(rs());
    t.push_back(rs());
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL reset[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic test_branch_flush();
    stim_t t [$];
    exp_t  e;
    // single pulse: redirect + one FLUSH slot, then RUN
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_RUN));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    // back-to-back branch reloads the flush window
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_RUN));
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_FL));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    // imem miss during FLUSH holds PC and the flush count
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_RUN));
    t.push_back(io(1'b0, 1'b0, 1'b0, FL_HOLD));
    t.push_back(io(1'b0, 1'b0, 1'b0, FL_HOLD));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL branch_flush[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t [$];
    exp_t  e;
    t.push_back(ld(1'b0, 5'd5,  5'd5,  5'd2, 1'b0, 1'b1, LU_E));  // rn hazard
    t.push_back(ld(1'b0, 5'd5,  5'd1,  5'd2, 1'b0, 1'b0, NORM));  // one cycle only
    t.push_back(ld(1'b0, 5'd31, 5'd31, 5'd2, 1'b0, 1'b1, NORM));  // zero reg
    t.push_back(ld(1'b0, 5'd31, 5'd1,  5'd31, 1'b1, 1'b1, NORM)); // zero reg via rm
    t.push_back(ld(1'b0, 5'd7,  5'd1,  5'd7, 1'b1, 1'b1, LU_E));  // rm hazard
    t.push_back(ld(1'b0, 5'd7,  5'd1,  5'd7, 1'b0, 1'b1, NORM));  // rm not read
    t.push_back(ld(1'b0, 5'd5,  5'd5,  5'd5, 1'b1, 1'b0, NORM));  // not a load
    t.push_back(ld(1'b0, 5'd0,  5'd0,  5'd9, 1'b0, 1'b1, LU_E));  // reg 0 is normal
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL load_use[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic test_branch_vs_load_use();
    stim_t t [$];
    exp_t  e;
    t.push_back(ld(1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b1, BR_RUN));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL branch_vs_load_use[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic test_imem_wait();
    stim_t t [$];
    exp_t  e;
    t.push_back(io(1'b0, 1'b0, 1'b0, MISS));
    t.push_back(io(1'b0, 1'b0, 1'b0, WAIT_E));
    t.push_back(io(1'b0, 1'b0, 1'b0, WAIT_E));
    t.push_back(io(1'b0, 1'b0, 1'b0, WAIT_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, WAIT_OK));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    // branch during the wait enters FLUSH
    t.push_back(io(1'b0, 1'b0, 1'b0, MISS));
    t.push_back(io(1'b1, 1'b0, 1'b0, BR_WT));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    // branch outranks a miss in RUN
    t.push_back(io(1'b1, 1'b0, 1'b0, BR_RUN));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL imem_wait[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic test_halt();
    stim_t t [$];
    exp_t  e;
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_RUN));
    t.push_back(io(1'b0, 1'b1, 1'b1, FL_HOLD));  // halt request in FLUSH
    t.push_back(io(1'b0, 1'b1, 1'b0, HALT_E));
    t.push_back(io(1'b1, 1'b1, 1'b0, HALT_E));   // branch ignored
    t.push_back(ld(1'b0, 5'd5, 5'd5, 5'd2, 1'b0, 1'b1, HALT_E));
    t.push_back(io(1'b0, 1'b0, 1'b0, HALT_E));
    t.push_back(rs());
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    t.push_back(io(1'b1, 1'b1, 1'b1, MISS));     // halt outranks branch
    t.push_back(io(1'b0, 1'b1, 1'b0, HALT_E));
    t.push_back(rs());
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    t.push_back(io(1'b1, 1'b1, 1'b0, BR_RUN));
    t.push_back(io(1'b0, 1'b1, 1'b0, FLUSH_E));
    t.push_back(io(1'b0, 1'b1, 1'b0, NORM));
    for (int i = 0; i < t.size(); i++) begin
      step(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL halt[%0d] outputs got %b want %b (mask %b)", i, obs, e.exp, e.mask);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    // exactly one FLUSH cycle since the last reset
    checks++;
    if (flush_cycles !== 32'd1) begin
      errors++;
      $display("FAIL flush_cycles got %0d want 1", flush_cycles);
    end
`endif
  endtask

  // Structural invariants on every cycle.
  always @(negedge clk) begin
    checks++;
    if ((ifid_write_en && ifid_flush) || (pc_sel_branch && !pc_write_en)) begin
      errors++;
      $display("FAIL invariant we=%b flush=%b sel=%b pcwe=%b", ifid_write_en, ifid_flush,
               pc_sel_branch, pc_write_en);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; br_taken = 1'b0; imem_valid = 1'b1; halt_req = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rn = 5'd1; id_rm = 5'd2; id_uses_rm = 1'b0;
    test_reset();
    test_branch_flush();
    test_load_use();
    test_branch_vs_load_use();
    test_imem_wait();
    test_halt();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
